// File: rtl/value_ctrl_multi.sv
// rtl/value_ctrl_multi.sv - NCH bounded values adjusted by debounced up/down/select keys with auto-repeat and host load
module value_ctrl_multi #(
    parameter int WIDTH        = 8,
    parameter int NCH          = 4,
    parameter int MIN          = 10,
    parameter int MAX          = 20,
    parameter int INIT         = 10,
    parameter int STEP         = 1,
    parameter int WRAP         = 1,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int REPEAT_DLY   = 25000000,
    parameter int REPEAT_PER   = 5000000,
    parameter int CW           = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_up,
    input  logic                   key_dn,
    input  logic                   key_sel,
    input  logic                   load_en,
    input  logic [CW-1:0]          load_ch,
    input  logic [WIDTH-1:0]       load_val,
    output logic [CW-1:0]          cur_ch,
    output logic [WIDTH-1:0]       out_value,
    output logic [NCH*WIDTH-1:0]   values,
    output logic                   changed
);

    localparam logic [WIDTH:0]   MIN_W    = (WIDTH+1)'(MIN);
    localparam logic [WIDTH:0]   MAX_W    = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   STEP_W   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] INIT_V   = WIDTH'(INIT);
    localparam logic [31:0]      DB_LAST  = 32'(DEBOUNCE_CYC - 1);
    localparam logic [31:0]      DLY_LAST = 32'(REPEAT_DLY - 1);
    localparam logic [31:0]      PER_LAST = 32'(REPEAT_PER - 1);
    localparam logic [CW:0]      NCH_W    = (CW+1)'(NCH);
    localparam logic [CW-1:0]    CH_LAST  = CW'(NCH - 1);

    // Key bit order: 0 = up, 1 = dn, 2 = sel; all levels active-low
    logic [2:0]  key_raw, sync1, sync2, deb, deb_d;
    logic [31:0] dcnt [3];
    logic [2:0]  press_ev, release_ev;

    assign key_raw    = {key_sel, key_dn, key_up};
    assign press_ev   = deb_d & ~deb;
    assign release_ev = ~deb_d & deb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            deb_d <= '1;
            for (int k = 0; k < 3; k++) dcnt[k] <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int k = 0; k < 3; k++) begin
                if (sync2[k] == deb[k]) begin
                    dcnt[k] <= '0;
                end else if (dcnt[k] == DB_LAST) begin
                    deb[k]  <= sync2[k];
                    dcnt[k] <= '0;
                end else begin
                    dcnt[k] <= dcnt[k] + 32'd1;
                end
            end
        end
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RPT} rpt_state_t;

    logic [1:0] step_ev;

    for (genvar g = 0; g < 2; g++) begin : g_rpt
        rpt_state_t  state, state_nxt;
        logic [31:0] cnt, cnt_nxt;
        logic        step_g;

        assign step_ev[g] = step_g;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // Release wins over a same-cycle repeat emission
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            step_g    = 1'b0;
            if (release_ev[g]) begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (press_ev[g]) begin
                            step_g  = 1'b1;
                            cnt_nxt = '0;
                            if (REPEAT_DLY != 0) state_nxt = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (cnt == DLY_LAST) begin
                            step_g    = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = S_RPT;
                        end else begin
                            cnt_nxt = cnt + 32'd1;
                        end
                    end
                    S_RPT: begin
                        if (cnt == PER_LAST) begin
                            step_g  = 1'b1;
                            cnt_nxt = '0;
                        end else begin
                            cnt_nxt = cnt + 32'd1;
                        end
                    end
                    default: state_nxt = S_IDLE;
                endcase
            end
        end
    end

    logic [WIDTH-1:0] vals     [NCH];
    logic [WIDTH-1:0] vals_nxt [NCH];
    logic [CW-1:0]    ch_nxt;
    logic [WIDTH:0]   cur_w, stepped, clamped;
    logic             do_up, do_dn, load_ok, any_diff;

    always_comb begin
        do_up   = step_ev[0] & ~step_ev[1];
        do_dn   = step_ev[1] & ~step_ev[0];
        cur_w   = {1'b0, vals[cur_ch]};
        stepped = cur_w;
        if (do_up) begin
            stepped = (cur_w + STEP_W > MAX_W) ? ((WRAP != 0) ? MIN_W : MAX_W) : cur_w + STEP_W;
        end else if (do_dn) begin
            stepped = (cur_w < MIN_W + STEP_W) ? ((WRAP != 0) ? MAX_W : MIN_W) : cur_w - STEP_W;
        end

        clamped = {1'b0, load_val};
        if (clamped < MIN_W)      clamped = MIN_W;
        else if (clamped > MAX_W) clamped = MAX_W;
        load_ok = load_en && ({1'b0, load_ch} < NCH_W);

        for (int i = 0; i < NCH; i++) vals_nxt[i] = vals[i];
        // Key step lands on the pre-advance channel; a load to the same channel overrides it
        if (do_up || do_dn) vals_nxt[cur_ch]  = stepped[WIDTH-1:0];
        if (load_ok)        vals_nxt[load_ch] = clamped[WIDTH-1:0];

        ch_nxt = cur_ch;
        if (press_ev[2]) ch_nxt = (cur_ch == CH_LAST) ? '0 : cur_ch + CW'(1);

        any_diff = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (vals_nxt[i] != vals[i]) any_diff = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) vals[i] <= INIT_V;
            cur_ch    <= '0;
            out_value <= INIT_V;
            changed   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) vals[i] <= vals_nxt[i];
            cur_ch    <= ch_nxt;
            out_value <= vals_nxt[ch_nxt];
            changed   <= any_diff;
        end
    end

    always_comb begin
        values = '0;
        for (int i = 0; i < NCH; i++) values[i*WIDTH +: WIDTH] = vals[i];
    end

endmodule

// File: tb/tb_value_ctrl_multi.sv
// tb/tb_value_ctrl_multi.sv - directed self-checking bench for value_ctrl_multi (wrap and saturate builds)
module tb_value_ctrl_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_up, key_dn, key_sel, load_en;
    logic [1:0]  load_ch;
    logic [7:0]  load_val;
    logic [1:0]  cur_ch, sat_cur_ch;
    logic [7:0]  out_value, sat_out_value;
    logic [31:0] values, sat_values;
    logic        changed, sat_changed;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    value_ctrl_multi #(.DEBOUNCE_CYC(4), .REPEAT_DLY(16), .REPEAT_PER(8), .WRAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .key_up(key_up), .key_dn(key_dn), .key_sel(key_sel),
        .load_en(load_en), .load_ch(load_ch), .load_val(load_val),
        .cur_ch(cur_ch), .out_value(out_value), .values(values), .changed(changed)
    );

    value_ctrl_multi #(.DEBOUNCE_CYC(4), .REPEAT_DLY(16), .REPEAT_PER(8), .WRAP(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .key_up(key_up), .key_dn(key_dn), .key_sel(key_sel),
        .load_en(load_en), .load_ch(load_ch), .load_val(load_val),
        .cur_ch(sat_cur_ch), .out_value(sat_out_value), .values(sat_values), .changed(sat_changed)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [1:0] ch, input logic [7:0] val);
        load_en  = 1'b1;
        load_ch  = ch;
        load_val = val;
        tick(1);
        load_en  = 1'b0;
    endtask

    initial begin
        int sel_exp [4];
        sel_exp = '{1, 2, 3, 0};
        rst_n = 1'b0; key_up = 1'b1; key_dn = 1'b1; key_sel = 1'b1;
        load_en = 1'b0; load_ch = '0; load_val = '0;
        tick(3);
        rst_n = 1'b1;

        // 1: reset state, single up tap
        chk("rst_out", out_value, 10);
        chk("rst_ch", cur_ch, 0);
        chk("rst_changed", changed, 0);
        chk("rst_values", values, 32'h0A0A0A0A);
        chk("rst_sat_values", sat_values, 32'h0A0A0A0A);
        chk("rst_sat_ch", sat_cur_ch, 0);
        key_up = 1'b0;
        tick(6);
        chk("t1_before", out_value, 10);
        tick(1);
        chk("t1_edge7", out_value, 11);
        chk("t1_changed", changed, 1);
        tick(1);
        chk("t1_changed_pulse", changed, 0);
        tick(2);
        key_up = 1'b1;
        tick(20);
        chk("t1_values", values, 32'h0A0A0A0B);

        // 2: overflow wraps vs saturates
        load(2'd0, 8'd20);
        chk("t2_load20", out_value, 20);
        chk("t2_load_changed", changed, 1);
        key_up = 1'b0;
        tick(7);
        chk("t2_wrap", out_value, 10);
        chk("t2_wrap_changed", changed, 1);
        chk("t2_sat", sat_out_value, 20);
        chk("t2_sat_changed", sat_changed, 0);
        key_up = 1'b1;
        tick(12);

        // 3: hold down, auto-repeat and underflow
        load(2'd0, 8'd15);
        tick(2);
        key_dn = 1'b0;
        tick(7);
        chk("t3_press", out_value, 14);
        tick(15);
        chk("t3_wait", out_value, 14);
        tick(1);
        chk("t3_first_rpt", out_value, 13);
        tick(8);
        chk("t3_rpt2", out_value, 12);
        tick(8);
        chk("t3_rpt3", out_value, 11);
        tick(16);
        chk("t3_wrap_under", out_value, 20);
        chk("t3_sat_under", sat_out_value, 10);
        chk("t3_sat_changed", sat_changed, 0);
        key_dn = 1'b1;
        tick(20);
        chk("t3_after_release", out_value, 20);

        // 4: bounce rejected, simultaneous up+dn dropped
        for (int b = 0; b < 5; b++) begin
            key_up = 1'b0;
            tick(3);
            key_up = 1'b1;
            tick(1);
        end
        tick(20);
        chk("t4_bounce", values, 32'h0A0A0A14);
        key_up = 1'b0;
        key_dn = 1'b0;
        tick(7);
        chk("t4_both_val", out_value, 20);
        chk("t4_both_changed", changed, 0);
        tick(20);
        chk("t4_both_hold", values, 32'h0A0A0A14);
        key_up = 1'b1;
        key_dn = 1'b1;
        tick(15);

        // 5: channel select wrap and per-channel step
        for (int s = 0; s < 6; s++) begin
            key_sel = 1'b0;
            tick(7);
            chk("t5_sel", cur_ch, sel_exp[s % 4]);
            key_sel = 1'b1;
            tick(8);
        end
        chk("t5_ch2_out", out_value, 10);
        key_up = 1'b0;
        tick(7);
        chk("t5_ch2_up", out_value, 11);
        chk("t5_only_ch2", values, 32'h0A0B0A14);
        key_up = 1'b1;
        tick(12);

        // 6: host load clamping, equal write, reset mid-hold
        load(2'd1, 8'd200);
        chk("t6_clamp_hi", values, 32'h0A0B1414);
        chk("t6_hi_changed", changed, 1);
        chk("t6_out_tracks", out_value, 11);
        load(2'd1, 8'd3);
        chk("t6_clamp_lo", values, 32'h0A0B0A14);
        load(2'd1, 8'd10);
        chk("t6_equal_changed", changed, 0);
        key_up = 1'b0;
        tick(10);
        chk("t6_hold_step", out_value, 12);
        rst_n = 1'b0;
        tick(2);
        chk("t6_rst_values", values, 32'h0A0A0A0A);
        chk("t6_rst_out", out_value, 10);
        chk("t6_rst_ch", cur_ch, 0);
        key_up = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(40);
        chk("t6_no_repeat", values, 32'h0A0A0A0A);
        chk("t6_no_change", changed, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
